// File: rtl/srt_div_iter_pkg.sv
// Shared state encoding and sizing helper for the iterative radix-2 divider.
// Used by srt_div_iter and, when DIV_LZ_SKIP_EN is defined, by lzc.
package div_pkg;

    localparam logic [2:0] DIV_ST_IDLE = 3'd0;
    localparam logic [2:0] DIV_ST_PREP = 3'd1;
    localparam logic [2:0] DIV_ST_CALC = 3'd2;
    localparam logic [2:0] DIV_ST_FIX  = 3'd3;
    localparam logic [2:0] DIV_ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = DIV_ST_IDLE,
        ST_PREP = DIV_ST_PREP,
        ST_CALC = DIV_ST_CALC,
        ST_FIX  = DIV_ST_FIX,
        ST_DONE = DIV_ST_DONE
    } div_state_e;

    // Bits needed to hold any value in 0..w inclusive.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/srt_div_iter_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
// Only compiled when DIV_LZ_SKIP_EN is defined.
`ifdef DIV_LZ_SKIP_EN
module lzc
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW   = div_cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`endif

// File: rtl/srt_div_iter.sv
// Iterative radix-2 restoring integer divider with valid/ready handshake and flush.
// Define DIV_LZ_SKIP_EN to skip the dividend's leading zeros (shorter latency).
module srt_div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div_zero,
    output logic             busy
);

    localparam int CW = div_cnt_w(WIDTH);

    div_state_e       state_q;
    logic [WIDTH-1:0] x_q, y_q, ay_q, quo_q, rem_q;
    logic [CW-1:0]    cnt_q;
    logic             sgn_q, sq_q, sr_q, dz_q;
    logic [TAG_W-1:0] tag_q;

    logic             out_valid_q, out_dz_q;
    logic [WIDTH-1:0] out_q_q, out_r_q;
    logic [TAG_W-1:0] out_tag_q;

    logic [WIDTH-1:0] ax_d, ay_d, q_init_d, quo_step_d, rem_step_d, q_fix_d, r_fix_d;
    logic [WIDTH:0]   rem_sh_d;
    logic [CW-1:0]    n_d;
    logic             sub_ok_d;

    assign ax_d = (sgn_q && x_q[WIDTH-1]) ? -x_q : x_q;
    assign ay_d = (sgn_q && y_q[WIDTH-1]) ? -y_q : y_q;

`ifdef DIV_LZ_SKIP_EN
    logic [CW-1:0] lz_d;

    lzc #(.WIDTH(WIDTH)) u_lzc (
        .data_i  (ax_d),
        .count_o (lz_d)
    );

    assign n_d = CW'(WIDTH) - lz_d;
`else
    assign n_d = CW'(WIDTH);
`endif

    // Pre-align the dividend so only its n significant bits are iterated.
    assign q_init_d = ax_d << (CW'(WIDTH) - n_d);

    // The shifted partial remainder needs one extra bit; after the
    // conditional subtract it is always below |y| and fits WIDTH bits again.
    assign rem_sh_d   = {rem_q, quo_q[WIDTH-1]};
    assign sub_ok_d   = rem_sh_d >= {1'b0, ay_q};
    assign rem_step_d = sub_ok_d ? WIDTH'(rem_sh_d - {1'b0, ay_q}) : rem_sh_d[WIDTH-1:0];
    assign quo_step_d = {quo_q[WIDTH-2:0], sub_ok_d};

    assign q_fix_d = sq_q ? -quo_q : quo_q;
    assign r_fix_d = sr_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            ay_q        <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            sq_q        <= 1'b0;
            sr_q        <= 1'b0;
            dz_q        <= 1'b0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_dz_q    <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_x;
                        y_q     <= in_y;
                        sgn_q   <= in_signed;
                        tag_q   <= in_tag;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    ay_q    <= ay_d;
                    quo_q   <= q_init_d;
                    rem_q   <= '0;
                    cnt_q   <= n_d;
                    sq_q    <= sgn_q & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
                    sr_q    <= sgn_q & x_q[WIDTH-1];
                    dz_q    <= (ay_d == '0);
                    state_q <= ((ay_d == '0) || (n_d == '0)) ? ST_FIX : ST_CALC;
                end
                ST_CALC: begin
                    rem_q <= rem_step_d;
                    quo_q <= quo_step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    out_q_q     <= dz_q ? '1 : q_fix_d;
                    out_r_q     <= dz_q ? x_q : r_fix_d;
                    out_dz_q    <= dz_q;
                    out_tag_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign out_valid    = out_valid_q;
    assign out_q        = out_q_q;
    assign out_r        = out_r_q;
    assign out_tag      = out_tag_q;
    assign out_div_zero = out_dz_q;

endmodule

// File: tb/tb_srt_div_iter.sv
// Scoreboard bench for srt_div_iter: arithmetic reference model, directed and random ops.
// Latency expectations follow DIV_LZ_SKIP_EN when it is defined.
module tb_srt_div_iter;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, in_signed;
    logic [W-1:0]  in_x, in_y;
    logic [TW-1:0] in_tag;
    logic          out_valid, out_ready, out_div_zero, busy;
    logic [W-1:0]  out_q, out_r;
    logic [TW-1:0] out_tag;

    srt_div_iter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_signed    (in_signed),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_q        (out_q),
        .out_r        (out_r),
        .out_tag      (out_tag),
        .out_div_zero (out_div_zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          dz;
        int            lat;
        int            e0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: plain signed/unsigned integer division on 64-bit values.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic [TW-1:0] tag);
        exp_t   e;
        longint sx, sy, ax;
        int     n;
        sx    = s ? longint'($signed(x)) : longint'(x);
        sy    = s ? longint'($signed(y)) : longint'(y);
        e.tag = tag;
        e.e0  = 0;
        if (sy == 0) begin
            e.q   = '1;
            e.r   = x;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            e.q  = W'(sx / sy);
            e.r  = W'(sx % sy);
            e.dz = 1'b0;
            ax   = (sx < 0) ? -sx : sx;
            n    = W;
`ifdef DIV_LZ_SKIP_EN
            n = 0;
            for (int i = 0; i < W; i++) if (ax[i]) n = i + 1;
`endif
            if (ax < 0) n = W;
            e.lat = (n == 0) ? 2 : n + 2;
        end
        return e;
    endfunction

    // Monitor: checks hold stability and in_ready while valid, pops on handshake.
    bit            started = 1'b0;
    int            first_cyc;
    logic [W-1:0]  hq, hr;
    logic [TW-1:0] ht;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (!started) begin
                started   = 1'b1;
                first_cyc = cyc;
                hq = out_q; hr = out_r; ht = out_tag;
            end else begin
                chk("hold_q", out_q, hq);
                chk("hold_r", out_r, hr);
                chk("hold_tag", out_tag, ht);
            end
            chk("in_ready_while_valid", in_ready, 0);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got q=0x%08h tag=%0d, expected no result", out_q, out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("q", out_q, e.q);
                    chk("r", out_r, e.r);
                    chk("tag", out_tag, e.tag);
                    chk("div_zero", out_div_zero, e.dz);
                    chk("latency", first_cyc - e.e0, e.lat);
                    $display("txn tag=%0d q=0x%08h r=0x%08h dz=%0d lat=%0d (exp q=0x%08h r=0x%08h lat=%0d)",
                             out_tag, out_q, out_r, out_div_zero, first_cyc - e.e0, e.q, e.r, e.lat);
                end
                started = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [TW-1:0] tag, input bit push);
        int   g = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got in_ready=0, expected 1 within 500 cycles");
            return;
        end
        in_x = x; in_y = y; in_signed = s; in_tag = tag; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (push) begin
            e    = model(x, y, s, tag);
            e.e0 = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag_s);
        chk({tag_s, "_in_ready"}, in_ready, 1);
        chk({tag_s, "_out_valid"}, out_valid, 0);
        chk({tag_s, "_busy"}, busy, 0);
        chk({tag_s, "_out_q"}, out_q, 0);
        chk({tag_s, "_out_r"}, out_r, 0);
        chk({tag_s, "_out_tag"}, out_tag, 0);
        chk({tag_s, "_div_zero"}, out_div_zero, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] rx, ry;
        logic         rs;
        int           g;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases
        issue(32'd100, 32'd7, 1'b0, 4'd3, 1'b1);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd1, 1'b1);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 4'd2, 1'b1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd4, 1'b1);
        issue(32'd5, 32'd0, 1'b0, 4'd5, 1'b1);
        issue(32'd0, 32'd9, 1'b0, 4'd6, 1'b1);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 4'd11, 1'b1);
        drain();

        // Back-pressure: hold result for 5 cycles, then release
        out_ready = 1'b0;
        issue(32'd1234, 32'd10, 1'b0, 4'd7, 1'b1);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("hold_valid_seen", out_valid, 1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_busy", busy, 0);

        // Flush mid-calculation discards the result
        issue(32'd100, 32'd7, 1'b0, 4'd8, 1'b0);
`ifdef DIV_LZ_SKIP_EN
        repeat (2) @(posedge clk);
`else
        repeat (8) @(posedge clk);
`endif
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        issue(32'd9, 32'd4, 1'b0, 4'd9, 1'b1);
        drain();

        // Flush in the accept cycle drops the request
        @(negedge clk);
        in_x = 32'd50; in_y = 32'd5; in_signed = 1'b0; in_tag = 4'd12;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_accept_busy", busy, 0);
        chk("flush_accept_in_ready", in_ready, 1);

        // Reset mid-calculation returns to reset values immediately
        issue(32'd100, 32'd7, 1'b0, 4'd10, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1 chk_reset_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomised operations with random consumer stalls
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rs = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin rx = $urandom_range(0, 1000); ry = $urandom_range(1, 50); end
                2: ry = '0;
                3: begin ry = '1; if ($urandom_range(0, 1) == 1) rx = 32'h8000_0000; end
                4: begin rx = $urandom_range(0, 255); ry = $urandom_range(256, 100000); end
                default: rx = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
            endcase
            issue(rx, ry, rs, 4'(k), 1'b1);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
